// File: rtl/bcd_seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver with per-frame BCD snapshot and one-clock dead time per slot.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros in the hundreds/tens digits.
module bcd_seg7_scan_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel,
  output logic        frame
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    UNITS    = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } slot_t;

  logic [DW-1:0] div_cnt_reg;
  slot_t         slot_reg, slot_next;
  logic [11:0]   snap_reg;
  logic          tick;
  logic          frame_next;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;
  logic [2:0]    dig_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    slot_next  = slot_reg;
    frame_next = 1'b0;
    nibble     = 4'h0;
    blank      = 1'b0;
    dig_next   = 3'b000;
    seg_next   = 7'h00;
    case (slot_reg)
      UNITS: begin
        if (tick) slot_next = TENS;
        nibble   = snap_reg[3:0];
        dig_next = 3'b001;
      end
      TENS: begin
        if (tick) slot_next = HUNDREDS;
        nibble   = snap_reg[7:4];
        dig_next = 3'b010;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (snap_reg[11:8] == 4'h0) && (snap_reg[7:4] == 4'h0);
`endif
      end
      HUNDREDS: begin
        // Frame boundary: the snapshot is taken on the same edge the scan wraps
        if (tick) begin
          slot_next  = UNITS;
          frame_next = 1'b1;
        end
        nibble   = snap_reg[11:8];
        dig_next = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (snap_reg[11:8] == 4'h0);
`endif
      end
      default: slot_next = UNITS;
    endcase
    // First clock of every slot stays dark to avoid ghosting between digits
    if (div_cnt_reg == '0) begin
      dig_next = 3'b000;
    end else if (!blank) begin
      seg_next = decode(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      slot_reg    <= UNITS;
      snap_reg    <= 12'h000;
      seg         <= 7'h00;
      dig_sel     <= 3'b000;
      frame       <= 1'b0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + DW'(1);
      slot_reg    <= slot_next;
      if (frame_next) snap_reg <= bcd_in;
      seg         <= seg_next;
      dig_sel     <= dig_next;
      frame       <= frame_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Bench for bcd_seg7_scan_driver: time-indexed reference model plus directed literal checks and random stimulus.
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_bcd_seg7_scan_driver;
  localparam int N = 4;
  localparam int F = 3 * N;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic [6:0]  seg;
  logic [2:0]  dig_sel;
  logic        frame;

  bcd_seg7_scan_driver #(.CLK_DIV(N)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in),
    .seg(seg), .dig_sel(dig_sel), .frame(frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [6:0] seg_tab [16];

  // Model: k_m counts clocks since reset release; position in scan follows from k_m arithmetic
  int          k_m = 0;
  logic [11:0] snap_m = 12'h000;
  logic [6:0]  e_seg = 7'h00;
  logic [2:0]  e_dig = 3'b000;
  logic        e_frame = 1'b0;

  always @(posedge clk) begin
    int pre, d, s;
    logic [3:0] nib;
    if (!rst_n) begin
      k_m = 0; snap_m = 12'h000; e_seg = 7'h00; e_dig = 3'b000; e_frame = 1'b0;
    end else begin
      pre = k_m;
      k_m = k_m + 1;
      d = pre % N;
      s = (pre / N) % 3;
      if (d == 0) begin
        e_seg = 7'h00; e_dig = 3'b000;
      end else begin
        e_dig = 3'(1 << s);
        nib = 4'((snap_m >> (4 * s)) & 12'hF);
        e_seg = seg_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (s == 2 && snap_m[11:8] == 4'h0) e_seg = 7'h00;
        if (s == 1 && snap_m[11:8] == 4'h0 && snap_m[7:4] == 4'h0) e_seg = 7'h00;
`endif
      end
      e_frame = (k_m % F == 0);
      if (e_frame) begin
        snap_m = bcd_in;
        $display("frame k=%0d snap=%03h", k_m, bcd_in);
      end
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", name, act, expv, k_m, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_seg", {5'b0, seg}, {5'b0, e_seg});
      check("model_dig", {9'b0, dig_sel}, {9'b0, e_dig});
      check("model_frame", {11'b0, frame}, {11'b0, e_frame});
    end
  end

  task automatic run_to(input int target);
    int guard = 0;
    while (k_m != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("run_to_timeout", 12'(k_m), 12'(target));
  endtask

  task automatic lit(input string name, input logic [6:0] s, input logic [2:0] d);
    check({name, "_seg"}, {5'b0, seg}, {5'b0, s});
    check({name, "_dig"}, {9'b0, dig_sel}, {9'b0, d});
  endtask

  initial begin
    logic [11:0] r;
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

    rst_n = 1'b0;
    bcd_in = 12'h000;
    repeat (3) begin
      @(negedge clk);
      lit("reset", 7'h00, 3'b000);
      check("reset_frame", {11'b0, frame}, 12'h0);
    end
    chk_en = 1'b1;

    // 987 held: first snapshot at clock 12, then units/tens/hundreds
    rst_n = 1'b1;
    bcd_in = 12'h987;
    run_to(11); lit("pre_frame_units", 7'h3F, 3'b100);
    run_to(12); check("first_frame", {11'b0, frame}, 12'h1);
    run_to(14); lit("u987", 7'h07, 3'b001);
    run_to(17); lit("dark", 7'h00, 3'b000);
    run_to(18); lit("t987", 7'h7F, 3'b010);
    run_to(22); lit("h987", 7'h6F, 3'b100);

    // 123 captured, 456 arrives mid-TENS and must wait for the next frame
    bcd_in = 12'h123;
    run_to(24); check("frame2", {11'b0, frame}, 12'h1);
    run_to(30); bcd_in = 12'h456; lit("t123", 7'h5B, 3'b010);
    run_to(34); lit("h123", 7'h06, 3'b100);
    run_to(38); lit("u456", 7'h7D, 3'b001);
    run_to(42); lit("t456", 7'h6D, 3'b010);
    run_to(46); lit("h456", 7'h66, 3'b100);

`ifndef LEADING_ZERO_BLANK_EN
    bcd_in = 12'h0A5;
    run_to(50); lit("u0A5", 7'h6D, 3'b001);
    run_to(54); lit("t0A5", 7'h40, 3'b010);
    run_to(58); lit("h0A5", 7'h3F, 3'b100);
`else
    bcd_in = 12'h007;
    run_to(50); lit("u007", 7'h07, 3'b001);
    run_to(54); lit("t007", 7'h00, 3'b010);
    run_to(58); lit("h007", 7'h00, 3'b100);
    bcd_in = 12'h070;
    run_to(62); lit("u070", 7'h3F, 3'b001);
    run_to(66); lit("t070", 7'h07, 3'b010);
    run_to(70); lit("h070", 7'h00, 3'b100);
`endif

    // One-clock reset in the middle of the HUNDREDS slot
    rst_n = 1'b0;
    @(negedge clk);
    lit("midrst", 7'h00, 3'b000);
    check("midrst_frame", {11'b0, frame}, 12'h0);
    rst_n = 1'b1;
    run_to(11); check("rst_frame_early", {11'b0, frame}, 12'h0);
    run_to(12); check("rst_frame_12", {11'b0, frame}, 12'h1);

    // Random values and occasional reset pulses, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          r = 12'($urandom);
          if ($urandom_range(0, 2) == 0) r[11:8] = 4'h0;
          if ($urandom_range(0, 2) == 0) r[7:4] = 4'h0;
          bcd_in = r;
        end
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
